// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer_bank peripheral: register offsets within a
// channel, CTRL bit positions and the CTRL register layout.
package timer_bank_pkg;

  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_PER_BIT = 1;
  localparam int CTRL_IRQ_BIT = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic enable;
  } ctrl_t;

  // Expand the four byte enables into a 32-bit write mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: counter, compare, control and sticky match flag.
// Bus decode lives in timer_bank; this block only sees per-register strobes.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmp_we,
  input  logic [CNT_W-1:0] cmp_wdata,
  input  logic [CNT_W-1:0] cmp_wmask,
  input  logic             ctrl_we,
  input  logic [2:0]       ctrl_wdata,
  input  logic             flag_clr,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] cmp,
  output logic [2:0]       ctrl,
  output logic             flag
);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] cmp_reg, cmp_next;
  ctrl_t            ctrl_reg, ctrl_next;
  logic             flag_reg, flag_next;

  ctrl_t wr_ctrl;
  logic  step;
  logic  hit;
  logic  per_eff;

  assign wr_ctrl = ctrl_t'(ctrl_wdata);

  // A counting step is suppressed by a CMP write or by a CTRL write that
  // disables the channel; a CTRL write that keeps it enabled does not slip.
  assign step    = ctrl_reg.enable && (cmp_reg != '0) && !cmp_we
                   && !(ctrl_we && !wr_ctrl.enable);
  assign hit     = step && (count_reg == cmp_reg - CNT_W'(1));
  assign per_eff = ctrl_we ? wr_ctrl.periodic : ctrl_reg.periodic;

  always_comb begin
    count_next = count_reg;
    cmp_next   = cmp_reg;
    ctrl_next  = ctrl_reg;
    flag_next  = flag_reg;

    if (flag_clr) flag_next = 1'b0;
    if (ctrl_we)  ctrl_next = wr_ctrl;

    if (cmp_we) begin
      cmp_next   = (cmp_reg & ~cmp_wmask) | (cmp_wdata & cmp_wmask);
      count_next = '0;
      flag_next  = 1'b0;
    end else if (ctrl_we && wr_ctrl.enable && !ctrl_reg.enable) begin
      count_next = '0;
    end else if (step) begin
      if (hit) begin
        // Set is evaluated after the clear so it wins on the same edge.
        flag_next = 1'b1;
        if (per_eff) begin
          count_next = '0;
        end else begin
          count_next       = cmp_reg;
          ctrl_next.enable = 1'b0;
        end
      end else begin
        count_next = count_reg + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      cmp_reg   <= '0;
      ctrl_reg  <= '0;
      flag_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      cmp_reg   <= cmp_next;
      ctrl_reg  <= ctrl_next;
      flag_reg  <= flag_next;
    end
  end

  assign count = count_reg;
  assign cmp   = cmp_reg;
  assign ctrl  = ctrl_reg;
  assign flag  = flag_reg;

endmodule

// File: rtl/timer_bank.sv
// Multi-channel timer peripheral on the vproc data-memory bus: address decode,
// NUM_CH timer_channel instances and a one-cycle registered response.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vproc_mem_req_o,
  input  logic [31:0]       vproc_mem_addr_o,
  input  logic              vproc_mem_we_o,
  input  logic [3:0]        vproc_mem_be_o,
  input  logic [31:0]       vproc_mem_wdata_o,
  output logic              vproc_mem_rvalid_i,
  output logic              vproc_mem_err_i,
  output logic [31:0]       vproc_mem_rdata_i,
  output logic [NUM_CH-1:0] timer_irq
);

  localparam int          CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [31:0] SPAN     = 32'(4 * NUM_CH);

  logic [31:0]         off;
  logic                in_range;
  logic [CH_IDX_W-1:0] ch_idx;
  logic [1:0]          reg_k;
  logic                acc_err;
  logic [31:0]         wmask;
  logic [2:0]          wr_ctrl;

  logic [CNT_W-1:0] count_arr [NUM_CH];
  logic [CNT_W-1:0] cmp_arr   [NUM_CH];
  logic [2:0]       ctrl_arr  [NUM_CH];
  logic [NUM_CH-1:0] flag_vec;
  logic [NUM_CH-1:0] irq_en_vec;

  logic [31:0] rd_word;
  logic        rvalid_reg, rvalid_next;
  logic        err_reg, err_next;
  logic [31:0] rdata_reg, rdata_next;

  assign off      = vproc_mem_addr_o - BASE_ADDR;
  assign in_range = (vproc_mem_addr_o >= BASE_ADDR) && (off < SPAN);
  assign ch_idx   = off[CH_IDX_W+1:2];
  assign reg_k    = off[1:0];
  assign acc_err  = !in_range || (vproc_mem_we_o && reg_k == REG_COUNT);
  assign wmask    = be_to_mask(vproc_mem_be_o);
  assign wr_ctrl  = {vproc_mem_wdata_o[CTRL_IRQ_BIT], vproc_mem_wdata_o[CTRL_PER_BIT],
                     vproc_mem_wdata_o[CTRL_EN_BIT]};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic ch_wr;
      assign ch_wr = vproc_mem_req_o && vproc_mem_we_o && !acc_err
                     && (ch_idx == CH_IDX_W'(gi));

      timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk        (clk),
        .rst        (rst),
        .cmp_we     (ch_wr && reg_k == REG_CMP),
        .cmp_wdata  (vproc_mem_wdata_o[CNT_W-1:0]),
        .cmp_wmask  (wmask[CNT_W-1:0]),
        .ctrl_we    (ch_wr && reg_k == REG_CTRL && vproc_mem_be_o[0]),
        .ctrl_wdata (wr_ctrl),
        .flag_clr   (ch_wr && reg_k == REG_STATUS && vproc_mem_be_o[0]
                     && vproc_mem_wdata_o[0]),
        .count      (count_arr[gi]),
        .cmp        (cmp_arr[gi]),
        .ctrl       (ctrl_arr[gi]),
        .flag       (flag_vec[gi])
      );

      assign irq_en_vec[gi] = ctrl_arr[gi][CTRL_IRQ_BIT];
    end
  endgenerate

  // Reads observe register state from before the request edge.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_idx == CH_IDX_W'(i)) begin
        case (reg_k)
          REG_CMP:   rd_word = 32'(cmp_arr[i]);
          REG_COUNT: rd_word = 32'(count_arr[i]);
          REG_CTRL:  rd_word = {29'b0, ctrl_arr[i]};
          default:   rd_word = {31'b0, flag_vec[i]};
        endcase
      end
    end
  end

  always_comb begin
    rvalid_next = vproc_mem_req_o;
    err_next    = vproc_mem_req_o && acc_err;
    rdata_next  = (vproc_mem_req_o && !acc_err && !vproc_mem_we_o) ? rd_word : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_reg <= 1'b0;
      err_reg    <= 1'b0;
      rdata_reg  <= '0;
    end else begin
      rvalid_reg <= rvalid_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
    end
  end

  assign vproc_mem_rvalid_i = rvalid_reg;
  assign vproc_mem_err_i    = err_reg;
  assign vproc_mem_rdata_i  = rdata_reg;
  assign timer_irq          = flag_vec & irq_en_vec;

endmodule

// File: tb/tb_timer_bank.sv
// Randomized self-checking bench for timer_bank. The reference model describes
// each channel by the edge its count last restarted, so count, flag and enable
// are derived arithmetically from elapsed cycles and the compare value.
module tb_timer_bank;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 8;
  localparam logic [31:0] BASE   = 32'h0000_0200;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [31:0]       addr = '0;
  logic [3:0]        be = '0;
  logic [31:0]       wdata = '0;
  logic              rvalid;
  logic              err;
  logic [31:0]       rdata;
  logic [NUM_CH-1:0] irq;

  timer_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE)) u_dut (
    .clk                (clk),
    .rst                (rst_n),
    .vproc_mem_req_o    (req),
    .vproc_mem_addr_o   (addr),
    .vproc_mem_we_o     (we),
    .vproc_mem_be_o     (be),
    .vproc_mem_wdata_o  (wdata),
    .vproc_mem_rvalid_i (rvalid),
    .vproc_mem_err_i    (err),
    .vproc_mem_rdata_i  (rdata),
    .timer_irq          (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Per-channel model: count restarted from 0 at edge m_s (when m_run);
  // m_held is the frozen count when stopped; matches at or after m_clr set the flag.
  int m_cmp  [NUM_CH];
  int m_s    [NUM_CH];
  int m_clr  [NUM_CH];
  int m_held [NUM_CH];
  bit m_run  [NUM_CH];
  bit m_per  [NUM_CH];
  bit m_ie   [NUM_CH];
  bit m_fb   [NUM_CH];

  function automatic int m_matches(int c, int t);
    int el = t - m_s[c];
    if (!m_run[c] || m_cmp[c] == 0 || el < m_cmp[c]) return 0;
    return m_per[c] ? el / m_cmp[c] : 1;
  endfunction

  function automatic int m_cnt(int c, int t);
    int el = t - m_s[c];
    if (!m_run[c]) return m_held[c];
    if (m_cmp[c] == 0) return 0;
    if (m_per[c]) return el % m_cmp[c];
    return (el >= m_cmp[c]) ? m_cmp[c] : el;
  endfunction

  function automatic bit m_en(int c, int t);
    if (!m_run[c]) return 1'b0;
    if (m_cmp[c] != 0 && !m_per[c] && (t - m_s[c]) >= m_cmp[c]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_flag(int c, int t);
    int n;
    if (m_fb[c]) return 1'b1;
    n = m_matches(c, t);
    if (n == 0) return 1'b0;
    return (m_s[c] + n * m_cmp[c]) >= m_clr[c];
  endfunction

  function automatic logic [NUM_CH-1:0] m_irq(int t);
    logic [NUM_CH-1:0] r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_flag(c, t) & m_ie[c];
    return r;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cmp[c] = 0; m_s[c] = cyc; m_clr[c] = cyc; m_held[c] = 0;
      m_run[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_fb[c] = 0;
    end
  endtask

  task automatic model_write(input int c, input int k, input logic [3:0] b,
                             input logic [31:0] d, input int e);
    logic [31:0] mask;
    logic [31:0] nv;
    bit oe, fl;
    int c0;
    case (k)
      0: begin
        mask = '0;
        for (int i = 0; i < 4; i++) if (b[i]) mask[8*i +: 8] = 8'hFF;
        nv = ((32'(m_cmp[c]) & ~mask) | (d & mask)) & 32'(CMAX);
        m_run[c] = m_en(c, e - 1);
        m_cmp[c] = int'(nv);
        m_s[c] = e; m_clr[c] = e; m_fb[c] = 0; m_held[c] = 0;
      end
      2: if (b[0]) begin
        oe = m_en(c, e - 1);
        c0 = m_cnt(c, e - 1);
        fl = m_flag(c, e - 1);
        m_fb[c] = fl; m_ie[c] = d[2]; m_per[c] = d[1];
        if (!d[0]) begin
          m_run[c] = 0; m_held[c] = c0;
        end else if (!oe) begin
          m_run[c] = 1; m_s[c] = e; m_clr[c] = e;
        end else begin
          m_s[c] = e - 1 - c0; m_clr[c] = e;
        end
      end
      3: if (b[0] && d[0]) begin
        m_fb[c] = 0; m_clr[c] = e;
      end
      default: ;
    endcase
  endtask

  bit          pend = 0;
  bit          pend_err = 0;
  logic [31:0] pend_d = '0;

  // One bus cycle: check the previous response and irq, then drive the next request.
  task automatic do_op(input bit rq, input bit w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, output int at_edge);
    logic [31:0] off;
    logic [31:0] exp_d;
    bit e_err;
    int c, k, e;
    @(negedge clk);
    chk("rvalid", 32'(rvalid), 32'(pend));
    if (pend) begin
      chk("err", 32'(err), 32'(pend_err));
      chk("rdata", rdata, pend_d);
    end
    chk("irq", 32'(irq), 32'(m_irq(cyc)));
    e = cyc + 1;
    at_edge = e;
    off = a - BASE;
    e_err = !((a >= BASE) && (off < 32'(4 * NUM_CH)));
    c = int'(off >> 2);
    k = int'(off & 32'd3);
    if (!e_err && w && k == 1) e_err = 1;
    exp_d = '0;
    if (rq && !e_err && !w) begin
      case (k)
        0: exp_d = 32'(m_cmp[c]);
        1: exp_d = 32'(m_cnt(c, cyc));
        2: exp_d = {29'b0, m_ie[c], m_per[c], m_en(c, cyc)};
        default: exp_d = {31'b0, m_flag(c, cyc)};
      endcase
    end
    if (rq && !e_err && w) model_write(c, k, b, d, e);
    pend = rq; pend_err = e_err; pend_d = exp_d;
    req = rq; we = w; addr = a; be = b; wdata = d;
    if (rq) $display("txn cyc=%0d we=%0b addr=%h be=%h wdata=%h", e, w, a, b, d);
  endtask

  task automatic idle(input int n);
    int x;
    for (int i = 0; i < n; i++) do_op(0, 0, '0, '0, '0, x);
  endtask

  task automatic rd(input int c, input int k);
    int x;
    do_op(1, 0, BASE + 32'(4 * c + k), 4'hF, '0, x);
  endtask

  task automatic wr(input int c, input int k, input logic [31:0] d, output int at_edge);
    do_op(1, 1, BASE + 32'(4 * c + k), 4'hF, d, at_edge);
  endtask

  task automatic rand_op(input int nch);
    int r, c, k, x;
    bit w;
    logic [3:0] b;
    logic [31:0] d, a;
    r = $urandom_range(0, 99);
    if (r < 25) begin
      do_op(0, 0, '0, '0, '0, x);
    end else if (r < 30) begin
      case ($urandom_range(0, 2))
        0: a = BASE - 32'd1;
        1: a = BASE + 32'(4 * NUM_CH);
        default: a = $urandom;
      endcase
      do_op(1, 1'($urandom_range(0, 1)), a, 4'hF, $urandom, x);
    end else begin
      c = $urandom_range(0, nch - 1);
      k = $urandom_range(0, 3);
      w = 1'($urandom_range(0, 1));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      case (k)
        0: d = ($urandom_range(0, 9) == 0) ? $urandom
                                            : (($urandom << 8) | 32'($urandom_range(0, 12)));
        2: d = ($urandom << 3) | 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      do_op(1, w, BASE + 32'(4 * c + k), b, d, x);
    end
  endtask

  initial begin
    int e0, x, nxt;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Every register reads zero after reset.
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 4; k++) rd(c, k);

    // One-shot on ch0: flag after exactly 10 cycles, COUNT parks at 10, enable drops.
    wr(0, 2, 32'h1, x);
    wr(0, 0, 32'd10, x);
    for (int i = 0; i < 12; i++) rd(0, 3);
    rd(0, 1);
    rd(0, 2);

    // Periodic with irq on ch2, clearing after each match and sometimes on it.
    wr(2, 2, 32'h7, x);
    wr(2, 0, 32'd5, e0);
    for (int i = 0; i < 100; i++) begin
      nxt = e0 + 1 + i;
      if (((nxt - e0) % 5 == 1) && ((i / 5) % 4 != 3)) wr(2, 3, 32'h1, x);
      else if (((nxt - e0) % 5 == 0) && ((i / 5) % 4 == 3)) wr(2, 3, 32'h1, x);
      else rd(2, 3);
    end

    // Maximum compare on ch3 while other channels are exercised randomly.
    wr(3, 2, 32'h7, x);
    wr(3, 0, 32'(CMAX), x);
    for (int i = 0; i < 700; i++) begin
      if (i % 7 == 0) rd(3, 1);
      else if (i % 11 == 0) wr(3, 3, 32'h1, x);
      else rand_op(3);
    end

    // Illegal accesses respond with err and change nothing.
    do_op(1, 0, BASE - 32'd1, 4'hF, '0, x);
    do_op(1, 1, BASE - 32'd1, 4'hF, 32'hFFFF_FFFF, x);
    do_op(1, 0, BASE + 32'(4 * NUM_CH), 4'hF, '0, x);
    do_op(1, 1, BASE + 32'(4 * NUM_CH), 4'hF, 32'hFFFF_FFFF, x);
    wr(0, 1, 32'd5, x);
    wr(3, 1, 32'd9, x);
    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 4; k++) rd(c, k);

    for (int i = 0; i < 2000; i++) rand_op(NUM_CH);

    // Asynchronous reset while ch1 is mid-count.
    wr(1, 2, 32'h0, x);
    wr(1, 2, 32'h5, x);
    wr(1, 0, 32'd20, x);
    idle(7);
    rd(1, 1);
    rd(0, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    chk("arst_rvalid", 32'(rvalid), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    model_reset();
    pend = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) rd(1, k);
    idle(30);
    rd(1, 3);
    rd(1, 1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
